// File: rtl/likelihood_writer.sv
// likelihood_writer: byte-write programming sequencer for one 64x64 RRAM
// likelihood cell. Walks bits 0..7 of the latched byte, driving a
// SET or RESET pulse per bit through the cell's column-control word.
// Optional program-verify with retries: define LIKELIHOOD_WRITER_VERIFY_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request, req_ready=1, all drives off
// SETUP  | column and BL/SL driven, word line low
// PULSE  | word line high, BL/SL and column unchanged
// HOLD   | word line low, BL/SL still held
// VERIFY | read strobe high, BL/SL/CBLEN off (verify build only)
// CHECK  | compare readback, retry or flag the bit (verify build only)
// NEXT   | one quiet cycle between bits, advance bit index
// DONE   | one-cycle done pulse with err_mask
module likelihood_writer #(
    parameter int Nword     = 6,
    parameter int T_SETUP   = 2,
    parameter int T_PULSE   = 4,
    parameter int T_HOLD    = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [Nword-1:0] req_row,
    input  logic [2:0]       req_byte,
    input  logic [7:0]       req_data,
    output logic [Nword+3:0] reg_lcs,
    output logic [Nword-1:0] adr_l,
    output logic             CWL_in,
    output logic             read_1,
    input  logic             verify_bit,
    output logic             done,
    output logic [7:0]       err_mask
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_PULSE  = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_VERIFY = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    // Verify phase is fixed at 2 cycles, so it also bounds the counter width.
    localparam int T_VERIFY = 2;
    localparam int T_MAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int T_MAX_SH = (T_MAX_SP > T_HOLD) ? T_MAX_SP : T_HOLD;
    localparam int T_MAX    = (T_MAX_SH > T_VERIFY) ? T_MAX_SH : T_VERIFY;
    localparam int CW       = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [2:0]       bit_idx;
    logic [Nword-1:0] row_q;
    logic [2:0]       byte_q;
    logic [7:0]       data_q;
    logic [Nword-1:0] col;
    logic             bit_val;

    assign col     = Nword'({byte_q, bit_idx});
    assign bit_val = data_q[bit_idx];

`ifdef LIKELIHOOD_WRITER_VERIFY_EN
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] LD_VERIFY = CW'(T_VERIFY - 1);

    logic [RW-1:0] retry;
    logic [7:0]    err_q;
`else
    localparam int unused_max_retry = MAX_RETRY;
    logic unused_verify_bit;
    assign unused_verify_bit = verify_bit;
`endif

    // Sequencer: state, phase down-counter, bit index and request latches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            row_q   <= '0;
            byte_q  <= '0;
            data_q  <= '0;
`ifdef LIKELIHOOD_WRITER_VERIFY_EN
            retry   <= '0;
            err_q   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        row_q   <= req_row;
                        byte_q  <= req_byte;
                        data_q  <= req_data;
                        bit_idx <= '0;
                        cnt     <= LD_SETUP;
                        state   <= S_SETUP;
`ifdef LIKELIHOOD_WRITER_VERIFY_EN
                        retry   <= '0;
                        err_q   <= '0;
`endif
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        cnt   <= LD_PULSE;
                        state <= S_PULSE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        cnt   <= LD_HOLD;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
`ifdef LIKELIHOOD_WRITER_VERIFY_EN
                        cnt   <= LD_VERIFY;
                        state <= S_VERIFY;
`else
                        state <= S_NEXT;
`endif
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`ifdef LIKELIHOOD_WRITER_VERIFY_EN
                S_VERIFY: begin
                    if (cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_CHECK: begin
                    if (verify_bit == bit_val) begin
                        state <= S_NEXT;
                    end else if (retry < RW'(MAX_RETRY)) begin
                        retry <= retry + RW'(1);
                        cnt   <= LD_SETUP;
                        state <= S_SETUP;
                    end else begin
                        err_q[bit_idx] <= 1'b1;
                        state          <= S_NEXT;
                    end
                end
`endif
                S_NEXT: begin
`ifdef LIKELIHOOD_WRITER_VERIFY_EN
                    retry <= '0;
`endif
                    if (bit_idx == 3'd7) begin
                        state <= S_DONE;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        cnt     <= LD_SETUP;
                        state   <= S_SETUP;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode straight from state so a reset edge clears every drive.
    always_comb begin
        reg_lcs = '0;
        CWL_in  = 1'b0;
        case (state)
            S_SETUP, S_HOLD: begin
                reg_lcs = {1'b1, 1'b1, bit_val, ~bit_val, col};
            end
            S_PULSE: begin
                reg_lcs = {1'b1, 1'b1, bit_val, ~bit_val, col};
                CWL_in  = 1'b1;
            end
            S_VERIFY, S_CHECK, S_NEXT: begin
                reg_lcs = {1'b1, 3'b000, col};
            end
            default: begin
                reg_lcs = '0;
            end
        endcase
    end

    assign req_ready = (state == S_IDLE);
    assign adr_l     = row_q;
    assign done      = (state == S_DONE);

`ifdef LIKELIHOOD_WRITER_VERIFY_EN
    assign read_1   = (state == S_VERIFY);
    assign err_mask = (state == S_DONE) ? err_q : 8'h00;
`else
    assign read_1   = 1'b0;
    assign err_mask = 8'h00;
`endif

endmodule

// File: doc/likelihood_writer.md
# likelihood_writer

Programming sequencer for one 64x64 RRAM likelihood cell: the write-side counterpart of the likelihood read path. It accepts one byte-write request (row, byte lane, 8 data bits), then drives the cell's column-control word, row address and word-line enable through a SET/RESET pulse sequence for each of the 8 bits. The outputs feed the likelihood cell's `reg_lcs`, `adr_l`, `CWL_in` and `read_1` inputs, multiplexed with the inference controller by the array top level. Optional program-verify reads each bit back through the cell's `bit_next` output and retries failed bits.

## Interface
- Nword, 6, log2 of array rows/columns
- T_SETUP, 2, cycles BL/SL are stable before the word line rises
- T_PULSE, 4, word-line high cycles per programming pulse
- T_HOLD, 2, cycles BL/SL are held after the word line falls
- MAX_RETRY, 3, extra pulses allowed per bit (verify build only)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  1  write request
- req_ready  out  1  high only in IDLE
- req_row  in  Nword  row address
- req_byte  in  3  byte lane (columns 8*req_byte .. 8*req_byte+7)
- req_data  in  8  bit i is written to column 8*req_byte+i
- reg_lcs  out  Nword+4  [Nword+3] cell select, [Nword+2] CBLEN, [Nword+1] CBL, [Nword] CSL, [Nword-1:0] column
- adr_l  out  Nword  row address
- CWL_in  out  1  word-line enable
- read_1  out  1  verify read strobe
- verify_bit  in  1  cell `bit_next` readback
- done  out  1  one-cycle pulse when the byte completes
- err_mask  out  8  bits that failed verify; valid with `done`

## Operation
- Handshake: the request is accepted on the cycle where `req_valid && req_ready`. Row, byte and data are latched on that cycle. Requests are ignored outside IDLE.
- States: IDLE -> SETUP -> PULSE -> HOLD -> (VERIFY -> CHECK) -> NEXT -> ... -> DONE -> IDLE.
- Bit order: bit 0 to bit 7. Column = {byte, bit_idx[2:0]}.
- SET (data 1): cell select=1, CBLEN=1, CBL=1, CSL=0. RESET (data 0): cell select=1, CBLEN=1, CBL=0, CSL=1.
- SETUP: column and BL/SL are driven and CWL_in=0, for T_SETUP cycles.
- PULSE: CWL_in=1 for T_PULSE cycles. BL/SL and the column are unchanged.
- HOLD: CWL_in=0 and BL/SL are held for T_HOLD cycles.
- NEXT: all BL/SL, CBLEN and CWL_in are 0 for one cycle. It then increments bit_idx, or goes to DONE after bit 7.
- CWL_in is never high in any cycle where the column, CBL, CSL or CBLEN differs from the previous cycle.
- DONE: `done`=1 for one cycle, `err_mask` is presented, then the block returns to IDLE.
- IDLE outputs: reg_lcs=0, CWL_in=0, read_1=0, adr_l=latched row (0 after reset).

## Timing
- Reset: on the first edge with rst_n=0, all outputs go to 0 except req_ready, which is 1. State goes to IDLE and the retry counter is cleared.
- Reset mid-pulse: CWL_in drops on that same edge.
- Without verify, per bit = T_SETUP+T_PULSE+T_HOLD+1 cycles. A byte takes 8*(that)+1 (DONE) cycles after the accept edge; with defaults, 73.
- req_ready is low from the cycle after accept through DONE. It returns high the cycle after DONE.
- A request presented in the DONE cycle is not accepted; it is accepted on the next cycle.
- T_SETUP, T_PULSE and T_HOLD must be at least 1. The cycle counter is sized to the maximum parameter.

## Configuration
- Macro: `LIKELIHOOD_WRITER_VERIFY_EN`.
- Defined: after HOLD, the block enters VERIFY, driving read_1=1, cell select=1, BL/SL/CBLEN=0, CWL_in=0 and the same column, for 2 cycles. In CHECK it samples verify_bit on the cycle after VERIFY ends.
  - Match: go to NEXT.
  - Mismatch with retries < MAX_RETRY: increment retry and go back to SETUP.
  - Mismatch with retries = MAX_RETRY: set err_mask[bit] and go to NEXT.
  - The retry counter clears in NEXT.
- Undefined: VERIFY and CHECK do not exist, read_1 is tied 0, verify_bit is ignored, and err_mask is always 0.

## Test plan
- Reset during PULSE of bit 3 -> next edge CWL_in=0, reg_lcs=0, req_ready=1. No done pulse.
- Write row 5, byte 2, data 0xA5, no verify, defaults:
  - Columns 16..23 are visited in order; SET on 16,18,21,23 and RESET on the others.
  - CWL_in is high exactly 4 cycles per bit.
  - done arrives 73 cycles after accept, with err_mask=0.
- Ordering checker on every cycle of a random write stream -> CWL_in is never asserted while the column or BL/SL changes, and adr_l is constant during the byte.
- Back-to-back: req_valid held high across DONE -> the second request is accepted the cycle after DONE, with no overlap.
- Verify build, verify_bit forced wrong for bit 4 only, MAX_RETRY=3:
  - Bit 4 receives 4 pulses.
  - done arrives with err_mask=0x10.
  - The other bits receive one pulse each.
- Verify build, verify_bit wrong on the first read of bit 0 then correct -> exactly 2 pulses on bit 0, err_mask=0x00.
